// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: opcode, command width, fetch FSM states.
// No logic of its own; latency n/a.
// Backpressure n/a; imported by fetch_unit and its queue.
package cpu_pkg;

  localparam int         CMD_W    = 32;
  localparam logic [5:0] OPC_JUMP = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // True when the command's major opcode is the jump opcode.
  function automatic logic is_jump(input logic [CMD_W-1:0] c);
    return c[CMD_W-1 -: 6] == OPC_JUMP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: DEPTH-entry circular buffer with wrap-around pointers and a flush.
// Latency: a push is visible at head the cycle after it is written into an empty queue.
// Backpressure: push ignored when full unless a pop frees a slot that cycle; flush beats push/pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction prefetcher: one request in flight to cmd_mem, responses queued for decode.
// Latency: request the cycle after IDLE; queued head valid one cycle after the response.
// Backpressure: no request while the queue is full; FETCH_JUMP_STALL_EN halts on jump opcodes.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             in_cmd_mem,
  output logic [PC_W-1:0]  adr_cmd,
  input  logic [CMD_W-1:0] cmd,
  input  logic             out_cmd_mem,
  output logic             fetch_valid,
  output logic [CMD_W-1:0] fetch_cmd,
  output logic [PC_W-1:0]  fetch_pc,
  input  logic             fetch_ready,
  input  logic             jump_valid,
  input  logic [PC_W-1:0]  jump_target,
  output logic             fetch_stalled
);

  localparam int QW = CMD_W + PC_W;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    next_state;
  logic [PC_W-1:0] pc;
  logic            accept;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  logic [QW-1:0]   q_head;
  logic [QW-1:0]   last_head;
  logic [QW-1:0]   shown;

  // A response only counts while a request is out; a redirect discards it.
  assign accept = (state == REQ) && out_cmd_mem && !jump_valid;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(QW)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (fetch_ready),
    .flush (jump_valid),
    .din   ({pc, cmd}),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: issue when room exists, retire on response, redirect overrides all.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (!q_full) next_state = REQ;
      REQ: begin
        if (out_cmd_mem) begin
          next_state = IDLE;
`ifdef FETCH_JUMP_STALL_EN
          if (is_jump(cmd)) next_state = HOLD;
`endif
        end
      end
      HOLD:    next_state = HOLD;
      default: next_state = IDLE;
    endcase
    if (jump_valid) next_state = IDLE;
  end

  // Program counter: redirect loads the target, an accepted response advances (wraps).
  always_ff @(posedge clk) begin
    if (rst)             pc <= '0;
    else if (jump_valid) pc <= jump_target;
    else if (accept)     pc <= pc + 1'b1;
  end

  // Remember the last presented head so an empty queue keeps showing it.
  always_ff @(posedge clk) begin
    if (rst) last_head <= '0;
    else     last_head <= shown;
  end

  assign shown       = q_empty ? last_head : q_head;
  assign in_cmd_mem  = (state == REQ);
  assign adr_cmd     = pc;
  assign fetch_valid = (q_count != '0);
  assign fetch_cmd   = shown[CMD_W-1:0];
  assign fetch_pc    = shown[QW-1:CMD_W];

`ifdef FETCH_JUMP_STALL_EN
  assign fetch_stalled = (state == HOLD);
`else
  assign fetch_stalled = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..8).
REQ-002 Parameter PC_W, default 4, meaning command address width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_cmd_mem  output  1  request strobe to cmd_mem.
REQ-006 adr_cmd  output  PC_W  command address for the current request.
REQ-007 cmd  input  32  command word from cmd_mem, valid when out_cmd_mem=1.
REQ-008 out_cmd_mem  input  1  cmd_mem response strobe.
REQ-009 fetch_valid  output  1  queue head is valid for decode.
REQ-010 fetch_cmd  output  32  queue head command word.
REQ-011 fetch_pc  output  PC_W  address the head command was fetched from.
REQ-012 fetch_ready  input  1  decode accepts the head this cycle.
REQ-013 jump_valid  input  1  redirect request from the operand/jump stage.
REQ-014 jump_target  input  PC_W  redirect address.
REQ-015 fetch_stalled  output  1  prefetch halted on a jump opcode (macro-dependent).

Function
REQ-016 States: IDLE, REQ, HOLD; the block resets to IDLE.
REQ-017 IDLE -> REQ when the queue count is below DEPTH and the block is not stalled; the block drives in_cmd_mem=1 and adr_cmd=pc on the following cycle.
REQ-018 In REQ, in_cmd_mem and adr_cmd stay stable until out_cmd_mem=1 is sampled.
REQ-019 On that sample, the block pushes cmd and its address into the queue, sets pc to pc+1 (modulo 2^PC_W, so 15 -> 0), and moves to IDLE with in_cmd_mem=0 for at least one cycle.
REQ-020 At most one request is in flight at any time.
REQ-021 A request is issued only when queue space exists, so a response is never dropped for lack of room.
REQ-022 Pop: fetch_valid && fetch_ready removes the head; the next head is visible the following cycle.
REQ-023 A push to an empty queue makes fetch_valid=1 one cycle after out_cmd_mem is sampled.
REQ-024 Simultaneous push and pop: the count is unchanged and both take effect.
REQ-025 jump_valid=1 flushes the queue, sets pc to jump_target, clears fetch_stalled, and forces fetch_valid=0 next cycle. A redirect has priority over a pop and a push in the same cycle.
REQ-026 Redirect while in REQ: in_cmd_mem is dropped next cycle, and the pending response is discarded, not pushed.
REQ-027 The block ignores out_cmd_mem whenever in_cmd_mem=0.
REQ-028 Empty queue: fetch_valid=0, and fetch_cmd/fetch_pc hold their last values. Full queue: no new request is issued.

Reset
REQ-029 While rst=1, every output is forced on the clock edge: in_cmd_mem=0, adr_cmd=0, fetch_valid=0, fetch_cmd=0, fetch_pc=0, fetch_stalled=0.
REQ-030 While rst=1, pc=0, the queue count is 0, and the state is IDLE.
REQ-031 Reset asserted mid-request abandons the request; a response arriving after reset is ignored.
REQ-032 The first request is issued on the second cycle after rst falls.

Configuration
REQ-033 Macro FETCH_JUMP_STALL_EN.
REQ-034 With the macro defined: a pushed command whose cmd[31:26]=6'b111111 moves the block to HOLD and sets fetch_stalled=1. No further requests are issued until jump_valid=1.
REQ-035 Without the macro defined: HOLD is unreachable, fetch_stalled is tied 0, and the block prefetches sequentially until redirected.

Structure
REQ-036 Shared package cpu_pkg holds:
 - OPC_JUMP=6'b111111
 - CMD_W=32
 - fetch_state_t (IDLE/REQ/HOLD)
REQ-037 The queue is a sub-module fetch_fifo (parameters DEPTH and width; ports push, pop, flush, full, empty, count, head), with wrap-around read/write pointers.

Verification
REQ-038 cmd_mem responds 1 cycle after request, fetch_ready=1 -> adr_cmd sequence 0,1,2,..., fetch_pc matches, no gaps in the fetch_cmd order.
REQ-039 fetch_ready=0 for 20 cycles -> exactly DEPTH=4 requests issued, then in_cmd_mem stays 0; releasing fetch_ready resumes at adr_cmd=4.
REQ-040 jump_valid=1, jump_target=9 while a request to address 3 is pending and the response arrives later -> that response is not pushed, and the next fetch_pc is 9.
REQ-041 pc=15 -> next adr_cmd=0.
REQ-042 With FETCH_JUMP_STALL_EN, cmd 0xFC000000 fetched -> fetch_stalled=1 and no further in_cmd_mem. jump_valid with target 2 -> resumes at 2.
REQ-043 rst=1 asserted while in_cmd_mem=1 -> all outputs 0 next cycle. out_cmd_mem=1 arriving one cycle later -> queue stays empty.
